two_bit_simplest_ctr: RTL and testbench

- Free-running 2-bit binary up-counter for use as a sequencing and timing primitive in the structural CPU datapath.
- Advances by one on every rising clock edge and wraps modulo 4.
- Built structurally: two D flip-flops plus next-state gates; no behavioural arithmetic.
- Has no enable, load or direction control.

---
 rtl/two_bit_simplest_ctr.sv | 54 +++++
 tb/tb_two_bit_simplest_ctr.sv | 124 ++++++++++++
 2 files changed

// File: rtl/two_bit_simplest_ctr.sv
// Structural 2-bit binary up-counter: two async-clear D flip-flops plus
// next-state gates, wrapping 00 -> 01 -> 10 -> 11 -> 00 on rising clk edges.

module two_bit_simplest_ctr_dff (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // its D input from before the edge, regardless of process evaluation order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

module two_bit_simplest_ctr (
    input  logic       clk,
    input  logic       reset_bar,
    output logic [1:0] count
);

    logic q0;
    logic q1;
    logic d0;
    logic d1;

    // Toggle the LSB every edge; the MSB toggles when the LSB carries out.
    assign d0 = ~q0;
    assign d1 = q1 ^ q0;

    two_bit_simplest_ctr_dff u_ff0 (
        .clk   (clk),
        .clr_n (reset_bar),
        .d     (d0),
        .q     (q0)
    );

    two_bit_simplest_ctr_dff u_ff1 (
        .clk   (clk),
        .clr_n (reset_bar),
        .d     (d1),
        .q     (q1)
    );

    assign count = {q1, q0};

endmodule

// File: tb/tb_two_bit_simplest_ctr.sv
// Directed bench for two_bit_simplest_ctr: table-driven per-edge vectors plus
// hand-written async-reset and clock-phase sequences.

module tb_two_bit_simplest_ctr;

    typedef struct {
        logic       reset_bar;
        logic [1:0] exp_count;
    } vec_t;

    logic       clk;
    logic       reset_bar;
    logic [1:0] count;

    int tests_run;
    int tests_failed;

    vec_t vecs[$];

    two_bit_simplest_ctr dut (
        .clk       (clk),
        .reset_bar (reset_bar),
        .count     (count)
    );

    // 20 ns period, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [1:0] actual, input logic [1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s at %0t: count=%b expected=%b", name, $time, actual, expected);
        end
    endtask

    task automatic add_vec(input logic rb, input logic [1:0] exp);
        vec_t v;
        v.reset_bar = rb;
        v.exp_count = exp;
        vecs.push_back(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_bar    = 1'b1;

        // Reset held across three edges, then a full count with two wraps,
        // a reset at count=00->... and a reset at count=11.
        add_vec(1'b0, 2'b00);
        add_vec(1'b0, 2'b00);
        add_vec(1'b0, 2'b00);
        add_vec(1'b1, 2'b01);
        add_vec(1'b1, 2'b10);
        add_vec(1'b1, 2'b11);
        add_vec(1'b1, 2'b00);
        add_vec(1'b1, 2'b01);
        add_vec(1'b1, 2'b10);
        add_vec(1'b1, 2'b11);
        add_vec(1'b1, 2'b00);
        add_vec(1'b1, 2'b01);
        add_vec(1'b0, 2'b00);
        add_vec(1'b1, 2'b01);
        add_vec(1'b1, 2'b10);
        add_vec(1'b1, 2'b11);
        add_vec(1'b0, 2'b00);
        add_vec(1'b1, 2'b01);

        // Power-up: assert reset with clk low, before any rising edge.
        #2 reset_bar = 1'b0;
        #1 check("powerup_reset", count, 2'b00);

        // Reset changes are applied on falling edges, clear of rising-edge setup/hold.
        foreach (vecs[i]) begin
            @(negedge clk);
            reset_bar = vecs[i].reset_bar;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), count, vecs[i].exp_count);
        end

        // Falling edge leaves state alone (count is 01 here).
        @(negedge clk);
        #1 check("falling_edge_hold", count, 2'b01);

        // Async reset mid-count with clk low, no clock edge involved.
        #3 reset_bar = 1'b0;
        #1 check("async_reset_clk_low", count, 2'b00);

        // Release itself causes no state change.
        @(negedge clk);
        reset_bar = 1'b1;
        #1 check("release_no_change", count, 2'b00);
        @(posedge clk);
        #1 check("first_edge_after_release", count, 2'b01);

        // Advance to 11, then assert reset during the clk-high phase.
        @(posedge clk);
        #1 check("step_to_10", count, 2'b10);
        @(posedge clk);
        #1 check("step_to_11", count, 2'b11);
        #3 reset_bar = 1'b0;
        #1 check("async_reset_clk_high_at_11", count, 2'b00);
        @(posedge clk);
        #1 check("edge_ignored_in_reset", count, 2'b00);
        @(negedge clk);
        reset_bar = 1'b1;
        @(posedge clk);
        #1 check("after_reset_from_11", count, 2'b01);

        // Free-running tail: period-4 pattern.
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp;
            exp = 2'(2 + k);
            @(posedge clk);
            #1 check($sformatf("tail%0d", k), count, exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
